// File: rtl/asa_noc_pkg.sv
// rtl/asa_noc_pkg.sv - shared constants, header layout and host FSM states for the ASA NoC host
package asa_noc_pkg;

  localparam logic [7:0] ASA_PKT_REQ  = 8'h01;
  localparam logic [7:0] ASA_PKT_RESP = 8'h02;

  localparam int HDR_TYPE_LSB = 24;
  localparam int HDR_CNT_LSB  = 16;
  localparam int HDR_SRC_LSB  = 8;
  localparam int HDR_DST_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_HDR,
    ST_TX_DATA,
    ST_RX_HDR,
    ST_RX_DATA,
    ST_DRAIN,
    ST_RESP
  } host_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/asa_noc_hdr.sv
// rtl/asa_noc_hdr.sv - packs the outbound request header and qualifies an inbound response header
module asa_noc_hdr
  import asa_noc_pkg::*;
#(
  parameter int XY_SZ      = 3,
  parameter int REQ_WORDS  = 3,
  parameter int RESP_WORDS = 2
) (
  input  logic [2*XY_SZ-1:0] own_id,
  input  logic [2*XY_SZ-1:0] req_dest,
  input  logic [2*XY_SZ-1:0] exp_src,
  input  logic [31:0]        rx_hdr,
  output logic [31:0]        tx_hdr,
  output logic               hdr_ok
);

  always_comb begin
    tx_hdr = '0;
    tx_hdr[HDR_TYPE_LSB +: 8] = ASA_PKT_REQ;
    tx_hdr[HDR_CNT_LSB  +: 8] = 8'(REQ_WORDS);
    tx_hdr[HDR_SRC_LSB  +: 8] = 8'(own_id);
    tx_hdr[HDR_DST_LSB  +: 8] = 8'(req_dest);
  end

  // The response must come back from the tile we addressed and be aimed at us.
  assign hdr_ok = (rx_hdr[HDR_TYPE_LSB +: 8] == ASA_PKT_RESP)
               && (rx_hdr[HDR_CNT_LSB  +: 8] == 8'(RESP_WORDS))
               && (rx_hdr[HDR_SRC_LSB  +: 8] == 8'(exp_src))
               && (rx_hdr[HDR_DST_LSB  +: 8] == 8'(own_id));

endmodule

// File: rtl/asa_noc_host.sv
// rtl/asa_noc_host.sv - host initiator: serialises one ASA request to the NoC and returns the matching response
module asa_noc_host
  import asa_noc_pkg::*;
#(
  parameter int XY_SZ      = 3,
  parameter int REQ_WORDS  = 3,
  parameter int RESP_WORDS = 2
) (
  input  logic                    clk_ctrl,
  input  logic                    clk_ctrl_rst_low,
  input  logic [2*XY_SZ-1:0]      HsrcId,
  input  logic [2*XY_SZ-1:0]      dest_id,
  input  logic                    req_val,
  output logic                    req_rdy,
  input  logic [32*REQ_WORDS-1:0] req_msg,
  output logic                    resp_val,
  input  logic                    resp_rdy,
  output logic [32*RESP_WORDS-1:0] resp_msg,
  output logic [7:0]              err_cnt,
  output logic                    stream_out_TVALID,
  output logic [31:0]             stream_out_TDATA,
  output logic [3:0]              stream_out_TKEEP,
  output logic                    stream_out_TLAST,
  input  logic                    stream_out_TREADY,
  input  logic                    stream_in_TVALID,
  input  logic [31:0]             stream_in_TDATA,
  input  logic [3:0]              stream_in_TKEEP,
  input  logic                    stream_in_TLAST,
  output logic                    stream_in_TREADY
);

  localparam logic [7:0] REQ_LAST  = 8'(REQ_WORDS - 1);
  localparam logic [7:0] RESP_LAST = 8'(RESP_WORDS - 1);

  host_state_t              state;
  logic [7:0]               cnt;
  logic [32*REQ_WORDS-1:0]  req_q;
  logic [2*XY_SZ-1:0]       dst_q;
  logic [32*RESP_WORDS-1:0] rx_buf;
  logic [32*RESP_WORDS-1:0] rx_merged;
  logic [31:0]              tx_hdr;
  logic                     hdr_ok;
  logic                     unused_tkeep;

  assign stream_out_TKEEP = 4'hF;
  assign unused_tkeep     = ^stream_in_TKEEP;

  asa_noc_hdr #(
    .XY_SZ      (XY_SZ),
    .REQ_WORDS  (REQ_WORDS),
    .RESP_WORDS (RESP_WORDS)
  ) u_hdr (
    .own_id   (HsrcId),
    .req_dest (dest_id),
    .exp_src  (dst_q),
    .rx_hdr   (stream_in_TDATA),
    .tx_hdr   (tx_hdr),
    .hdr_ok   (hdr_ok)
  );

  // Response words land in rx_buf and only reach resp_msg once the whole packet is good.
  always_comb begin
    rx_merged = rx_buf;
    rx_merged[32*cnt +: 32] = stream_in_TDATA;
  end

  always_ff @(posedge clk_ctrl or negedge clk_ctrl_rst_low) begin
    if (!clk_ctrl_rst_low) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      req_q             <= '0;
      dst_q             <= '0;
      rx_buf            <= '0;
      req_rdy           <= 1'b1;
      resp_val          <= 1'b0;
      resp_msg          <= '0;
      err_cnt           <= '0;
      stream_out_TVALID <= 1'b0;
      stream_out_TDATA  <= '0;
      stream_out_TLAST  <= 1'b0;
      stream_in_TREADY  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_val) begin
            req_q             <= req_msg;
            dst_q             <= dest_id;
            req_rdy           <= 1'b0;
            stream_out_TVALID <= 1'b1;
            stream_out_TDATA  <= tx_hdr;
            stream_out_TLAST  <= 1'b0;
            state             <= ST_TX_HDR;
          end
        end
        ST_TX_HDR: begin
          if (stream_out_TREADY) begin
            cnt              <= '0;
            stream_out_TDATA <= req_q[31:0];
            stream_out_TLAST <= (REQ_LAST == 8'd0);
            state            <= ST_TX_DATA;
          end
        end
        ST_TX_DATA: begin
          if (stream_out_TREADY) begin
            if (cnt == REQ_LAST) begin
              stream_out_TVALID <= 1'b0;
              stream_out_TDATA  <= '0;
              stream_out_TLAST  <= 1'b0;
              stream_in_TREADY  <= 1'b1;
              state             <= ST_RX_HDR;
            end else begin
              cnt              <= cnt + 8'd1;
              stream_out_TDATA <= req_q[32*(cnt + 8'd1) +: 32];
              stream_out_TLAST <= ((cnt + 8'd1) == REQ_LAST);
            end
          end
        end
        ST_RX_HDR: begin
          if (stream_in_TVALID) begin
            if (hdr_ok && !stream_in_TLAST) begin
              cnt   <= '0;
              state <= ST_RX_DATA;
            end else begin
              err_cnt <= sat_inc8(err_cnt);
              if (!stream_in_TLAST) state <= ST_DRAIN;
            end
          end
        end
        ST_RX_DATA: begin
          if (stream_in_TVALID) begin
            rx_buf <= rx_merged;
            if (stream_in_TLAST && cnt == RESP_LAST) begin
              resp_msg         <= rx_merged;
              resp_val         <= 1'b1;
              stream_in_TREADY <= 1'b0;
              state            <= ST_RESP;
            end else if (stream_in_TLAST) begin
              err_cnt <= sat_inc8(err_cnt);
              state   <= ST_RX_HDR;
            end else if (cnt == RESP_LAST) begin
              err_cnt <= sat_inc8(err_cnt);
              state   <= ST_DRAIN;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (stream_in_TVALID && stream_in_TLAST) state <= ST_RX_HDR;
        end
        ST_RESP: begin
          if (resp_rdy) begin
            resp_val <= 1'b0;
            req_rdy  <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/asa_noc_host.md
Name: asa_noc_host

Overview:
Host-side initiator for the ASA NoC protocol, i.e. the other end of the accelerator tile's decoder/encoder pair.
- Accepts one ASA request from a local controller, serialises it into a 32-bit AXI-stream NoC packet (header plus payload) addressed to the ASA tile.
- Waits for the matching response packet, checks and deserialises it, and presents the response to the controller.
- Sits in a host/controller tile on clk_ctrl, in front of that tile's noc_buffer_out / noc_buffer_in CDC pair.

Parameters:
XY_SZ, 3, bits per X/Y coordinate; tile id is 2*XY_SZ bits; XY_SZ <= 4 required.
REQ_WORDS, 3, 32-bit payload words per request, 1..255.
RESP_WORDS, 2, 32-bit payload words per response, 1..255.

Ports:
clk_ctrl  in  1  block clock
clk_ctrl_rst_low  in  1  reset, asynchronous, active-low
HsrcId  in  2*XY_SZ  own tile id
dest_id  in  2*XY_SZ  ASA tile id, sampled with the request
req_val  in  1  request valid
req_rdy  out  1  request ready
req_msg  in  32*REQ_WORDS  request payload; word i = req_msg[32*i +: 32]
resp_val  out  1  response valid
resp_rdy  in  1  response ready
resp_msg  out  32*RESP_WORDS  response payload; word i at [32*i +: 32]
err_cnt  out  8  saturating count of discarded inbound packets
stream_out_TVALID/TDATA[31:0]/TKEEP[3:0]/TLAST  out  toward NoC
stream_out_TREADY  in  1
stream_in_TVALID/TDATA[31:0]/TKEEP[3:0]/TLAST  in  from NoC
stream_in_TREADY  out  1

Behaviour:
- Header word fields: [31:24] type (0x01 request, 0x02 response); [23:16] payload word count; [15:8] source id, zero-extended; [7:0] destination id, zero-extended.
- Reset: FSM to IDLE. req_rdy=1; resp_val=0; resp_msg=0; err_cnt=0; stream_out_TVALID=0, TLAST=0, TDATA=0; TKEEP=4'hF constant; stream_in_TREADY=0. Reset mid-packet abandons it with no flush.
- FSM states: IDLE, TX_HDR, TX_DATA, RX_HDR, RX_DATA, DRAIN, RESP.
- IDLE: req_rdy=1. On req_val, capture req_msg and dest_id, go to TX_HDR. The header is presented the next cycle (1-cycle latency).
- TX_HDR: TVALID=1, TDATA = {0x01, REQ_WORDS, HsrcId, dest_id}. On TREADY go to TX_DATA with word counter=0.
- TX_DATA: TDATA = captured word[cnt]; TLAST=1 only when cnt==REQ_WORDS-1. cnt advances only on TVALID&TREADY. The final beat goes to RX_HDR.
- TVALID/TDATA/TLAST are registered and stable while TREADY=0. There are no bubbles between beats when TREADY is held high.
- RX_HDR: stream_in_TREADY=1. A header beat is accepted when type==0x02, count==RESP_WORDS, dest==HsrcId and src==captured dest.
  - Accepted header: go to RX_DATA, cnt=0.
  - Rejected header: err_cnt++; go to DRAIN, or stay in RX_HDR if that beat has TLAST.
  - Header beat with TLAST that would otherwise match: rejected, err_cnt++.
- RX_DATA: each beat stores into resp word[cnt].
  - TLAST on cnt==RESP_WORDS-1: go to RESP.
  - TLAST early: discard the packet, err_cnt++, go to RX_HDR.
  - cnt==RESP_WORDS-1 without TLAST: err_cnt++, go to DRAIN.
- DRAIN: TREADY=1, discard beats until a TLAST beat, then go to RX_HDR.
- RESP: stream_in_TREADY=0; resp_val=1 with resp_msg stable until resp_rdy, then go to IDLE (req_rdy=1 next cycle). resp_msg holds its value after the handshake.
- Only one transaction is outstanding at a time. req_val outside IDLE is ignored (req_rdy=0).
- err_cnt saturates at 0xFF. Inbound TKEEP is ignored.

Decomposition:
- Package asa_noc_pkg holds: type codes ASA_PKT_REQ=8'h01 and ASA_PKT_RESP=8'h02; header field offsets; the host FSM state enum.
- One combinational sub-module, asa_noc_hdr, packs the request header and checks the response header, exporting hdr_ok.

Test Plan:
- XY_SZ=3, REQ_WORDS=3, RESP_WORDS=2, HsrcId=6'h0A, dest_id=6'h13, req_msg={32'hC,32'hB,32'hA}, TREADY=1 -> out beats 0x01030A13, 0xA, 0xB, 0xC with TLAST on 0xC. Then inject 0x0202130A, 0x11, 0x22(TLAST) -> resp_val=1, resp_msg={32'h22,32'h11}, err_cnt=0.
- stream_out_TREADY toggling 1/0 every cycle -> each beat held stable while stalled; same 4 beats in order, no duplicates.
- Response header with src=0x15 (3-beat packet), followed by a valid response -> first packet drained, err_cnt=1, second delivered correctly.
- Valid header then only 1 data beat with TLAST -> err_cnt=1, no resp_val; a subsequent correct packet is delivered.
- resp_rdy held 0 for 10 cycles -> resp_val and resp_msg stable, stream_in_TREADY=0, req_rdy=0; resp_rdy=1 -> IDLE with req_rdy=1 next cycle.
- Assert clk_ctrl_rst_low=0 during TX_DATA beat 2 -> outputs take reset values immediately; after release a new request starts with a header beat.
